io_mailbox: RTL and testbench
=============================

IO_MAILBOX -- requirements
Module: io_mailbox

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO; power of two, 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 cs  input  1  bus select; 1 = access targets this block.
REQ-005 wr_rd  input  1  bus direction; 1 = write, 0 = read.
REQ-006 addr  input  32  bus address; only addr[3:2] decoded (register offset).
REQ-007 data_bus_write  input  32  write data from the CPU.
REQ-008 data_bus_read  output  32  read data to the CPU.
REQ-009 tx_data  output  32  head word of the TX FIFO.
REQ-010 tx_valid  output  1  TX head word valid.
REQ-011 tx_ready  input  1  sink accepts tx_data.
REQ-012 rx_data  input  32  incoming word.
REQ-013 rx_valid  input  1  rx_data valid.
REQ-014 rx_ready  output  1  block can accept rx_data.
REQ-015 irq  output  1  interrupt request, level.

Function
REQ-016 Register map by addr[3:2]: 0 TXDATA (W), 1 RXDATA (R, pops), 2 STATUS (R), 3 CONTROL (R/W).
REQ-017 Bus access: write when cs=1 and wr_rd=1; read when cs=1 and wr_rd=0; one access per cycle, no wait states.
REQ-018 data_bus_read is combinational from addr and current registered state, valid in the same cycle; 0 when cs=0, wr_rd=1, or reading TXDATA.
REQ-019 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_overflow (sticky), bit5 rx_underflow (sticky), [12:8] tx_count, [20:16] rx_count, other bits 0.
REQ-020 CONTROL write: bit0 flush (self-clearing, reads 0), bit1 tx_enable (stored), bit2 clear sticky flags (self-clearing, reads 0), bit3 irq_en (stored); read returns {28'b0, irq_en, 1'b0, tx_enable, 1'b0}.
REQ-021 TXDATA write pushes data_bus_write iff TX FIFO not full at cycle start; when full, the word is dropped and tx_overflow is set.
REQ-022 tx_valid = tx_enable AND NOT tx_empty; tx_data = TX head, and holds stable while tx_valid=1 and tx_ready=0.
REQ-023 TX pop when tx_valid=1 and tx_ready=1; simultaneous CPU push and port pop leaves tx_count unchanged (push still rejected if full at cycle start).
REQ-024 rx_ready = NOT rx_full; RX push when rx_valid=1 and rx_ready=1.
REQ-025 RXDATA read returns RX head and pops it in that cycle; if RX empty, returns 0, no pop, sets rx_underflow.
REQ-026 Simultaneous RX push and CPU pop leaves rx_count unchanged; a pop from a full FIFO does not enable a push in that same cycle (rx_ready is from cycle-start state).
REQ-027 FIFOs are circular buffers with read/write pointers wrapping modulo DEPTH; count ranges 0..DEPTH.
REQ-028 Flush empties both FIFOs (pointers and counts to 0) and takes priority over any push/pop in the same cycle; stored data and sticky flags remain unchanged.
REQ-029 Clear-sticky takes priority over a same-cycle event that would set a sticky flag.
REQ-030 irq = irq_en AND NOT rx_empty, registered-state based (no combinational path from bus inputs).

Reset
REQ-031 When rst=0 at a rising edge: both FIFOs empty, counts 0, tx_enable=0, irq_en=0, sticky flags 0.
REQ-032 Outputs during and after reset: tx_valid=0, rx_ready=1, irq=0, data_bus_read=0 unless read-selected (STATUS reads 0x0000_000A).
REQ-033 Reset mid-transfer discards FIFO contents; no handshake completes in a reset cycle.

Verification
REQ-034 Reset, read STATUS -> 0x0000_000A; CONTROL -> 0.
REQ-035 tx_enable=1, tx_ready=0, write 9 words 1..9 (DEPTH=8) -> tx_count=8, tx_full=1, tx_overflow=1; set tx_ready=1 -> tx_data 1..8 in order on consecutive cycles, then tx_valid=0.
REQ-036 Drive rx_valid with 0xA0..0xA8 -> rx_ready=0 after 8 words, 0xA8 held; read RXDATA 8 times -> 0xA0..0xA7; 9th read -> 0, rx_underflow=1.
REQ-037 RX count 3, RX push and RXDATA read in same cycle -> rx_count stays 3, FIFO order preserved.
REQ-038 irq_en=1, push one RX word -> irq=1 next cycle; read it -> irq=0; write CONTROL bit0 with both FIFOs partly full -> both empty, tx_enable/irq_en retained.
REQ-039 Exercise pointer wrap: 20 push/pop cycles at count 5 -> data order intact, counts never exceed DEPTH.

Source files
------------

// File: rtl/io_mailbox.sv
// -----------------------------------------------------------------------------
// io_mailbox
//
// CPU-facing mailbox with one outbound (TX) and one inbound (RX) word FIFO.
// The CPU reaches four registers through a zero-wait-state select/direction
// bus. The TX FIFO drains onto a valid/ready stream port. The RX FIFO fills
// from a valid/ready stream port.
//
// Register map (addr[3:2]):
//   0 TXDATA  (W)   push a word into the TX FIFO
//   1 RXDATA  (R)   pop and return the RX head word
//   2 STATUS  (R)   FIFO flags, sticky error flags and counts
//   3 CONTROL (R/W) bit0 flush, bit1 tx_enable, bit2 clear sticky, bit3 irq_en
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous reset, active low
//   cs, wr_rd      bus select and direction (1 = write, 0 = read)
//   addr           bus address, only bits [3:2] are decoded
//   data_bus_write CPU write data
//   data_bus_read  CPU read data, combinational from addr and current state
//   tx_data        TX FIFO head word
//   tx_valid       tx_data valid (TX enabled and TX FIFO not empty)
//   tx_ready       downstream sink accepts tx_data
//   rx_data        incoming word
//   rx_valid       rx_data valid
//   rx_ready       RX FIFO has room
//   irq            level interrupt: irq_en and RX FIFO not empty
// -----------------------------------------------------------------------------
module io_mailbox #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] addr,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  // Pointer width and count width. The count needs one more bit than the
  // pointer so it can represent a completely full FIFO (count == DEPTH).
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       bus_wr;
  logic       bus_rd;
  logic [1:0] reg_sel;

  assign bus_wr  = cs & wr_rd;
  assign bus_rd  = cs & ~wr_rd;
  assign reg_sel = addr[3:2];

  // Address bits outside the register offset are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  logic ctrl_wr;
  logic flush;
  logic clear_sticky;

  assign ctrl_wr      = bus_wr && (reg_sel == REG_CONTROL);
  assign flush        = ctrl_wr & data_bus_write[0];
  assign clear_sticky = ctrl_wr & data_bus_write[2];

  // ---------------------------------------------------------------------------
  // Control and sticky flag state
  // ---------------------------------------------------------------------------
  logic tx_enable_reg,    tx_enable_next;
  logic irq_en_reg,       irq_en_next;
  logic tx_overflow_reg,  tx_overflow_next;
  logic rx_underflow_reg, rx_underflow_next;

  // ---------------------------------------------------------------------------
  // TX FIFO state
  // ---------------------------------------------------------------------------
  logic [31:0]   tx_mem [DEPTH];
  logic [PW-1:0] tx_wptr_reg,  tx_wptr_next;
  logic [PW-1:0] tx_rptr_reg,  tx_rptr_next;
  logic [CW-1:0] tx_count_reg, tx_count_next;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push_req;
  logic          tx_push;
  logic          tx_pop;

  assign tx_full  = (tx_count_reg == CW'(DEPTH));
  assign tx_empty = (tx_count_reg == '0);

  // Fullness is judged on cycle-start state, so a word offered while the
  // FIFO is full is dropped even if the port drains an entry this cycle.
  assign tx_push_req = bus_wr && (reg_sel == REG_TXDATA);
  assign tx_push     = tx_push_req && !tx_full;

  assign tx_valid = tx_enable_reg && !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_data  = tx_mem[tx_rptr_reg];

  // ---------------------------------------------------------------------------
  // RX FIFO state
  // ---------------------------------------------------------------------------
  logic [31:0]   rx_mem [DEPTH];
  logic [PW-1:0] rx_wptr_reg,  rx_wptr_next;
  logic [PW-1:0] rx_rptr_reg,  rx_rptr_next;
  logic [CW-1:0] rx_count_reg, rx_count_next;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;
  logic          rx_pop_req;
  logic          rx_pop;
  logic [31:0]   rx_head;

  assign rx_full  = (rx_count_reg == CW'(DEPTH));
  assign rx_empty = (rx_count_reg == '0);

  // rx_ready comes from cycle-start state only, so a CPU pop from a full
  // FIFO does not open a slot for the port in that same cycle.
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;

  assign rx_pop_req = bus_rd && (reg_sel == REG_RXDATA);
  assign rx_pop     = rx_pop_req && !rx_empty;
  assign rx_head    = rx_mem[rx_rptr_reg];

  // ---------------------------------------------------------------------------
  // Next-state logic: TX FIFO pointers and count
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_wptr_next  = tx_wptr_reg;
    tx_rptr_next  = tx_rptr_reg;
    tx_count_next = tx_count_reg;
    if (flush) begin
      // Flush overrides any same-cycle push or pop.
      tx_wptr_next  = '0;
      tx_rptr_next  = '0;
      tx_count_next = '0;
    end else begin
      if (tx_push) begin
        tx_wptr_next = tx_wptr_reg + PW'(1);
      end
      if (tx_pop) begin
        tx_rptr_next = tx_rptr_reg + PW'(1);
      end
      tx_count_next = tx_count_reg + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: RX FIFO pointers and count
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_wptr_next  = rx_wptr_reg;
    rx_rptr_next  = rx_rptr_reg;
    rx_count_next = rx_count_reg;
    if (flush) begin
      rx_wptr_next  = '0;
      rx_rptr_next  = '0;
      rx_count_next = '0;
    end else begin
      if (rx_push) begin
        rx_wptr_next = rx_wptr_reg + PW'(1);
      end
      if (rx_pop) begin
        rx_rptr_next = rx_rptr_reg + PW'(1);
      end
      rx_count_next = rx_count_reg + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: control bits and sticky error flags
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_enable_next    = tx_enable_reg;
    irq_en_next       = irq_en_reg;
    tx_overflow_next  = tx_overflow_reg;
    rx_underflow_next = rx_underflow_reg;

    if (ctrl_wr) begin
      tx_enable_next = data_bus_write[1];
      irq_en_next    = data_bus_write[3];
    end

    // Clearing wins over any event that would set a flag in the same cycle.
    if (clear_sticky) begin
      tx_overflow_next  = 1'b0;
      rx_underflow_next = 1'b0;
    end else begin
      if (tx_push_req && tx_full) begin
        tx_overflow_next = 1'b1;
      end
      if (rx_pop_req && rx_empty) begin
        rx_underflow_next = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. A reset cycle discards all FIFO contents and lets no
  // handshake take effect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wptr_reg      <= '0;
      tx_rptr_reg      <= '0;
      tx_count_reg     <= '0;
      rx_wptr_reg      <= '0;
      rx_rptr_reg      <= '0;
      rx_count_reg     <= '0;
      tx_enable_reg    <= 1'b0;
      irq_en_reg       <= 1'b0;
      tx_overflow_reg  <= 1'b0;
      rx_underflow_reg <= 1'b0;
    end else begin
      tx_wptr_reg      <= tx_wptr_next;
      tx_rptr_reg      <= tx_rptr_next;
      tx_count_reg     <= tx_count_next;
      rx_wptr_reg      <= rx_wptr_next;
      rx_rptr_reg      <= rx_rptr_next;
      rx_count_reg     <= rx_count_next;
      tx_enable_reg    <= tx_enable_next;
      irq_en_reg       <= irq_en_next;
      tx_overflow_reg  <= tx_overflow_next;
      rx_underflow_reg <= rx_underflow_next;
    end
  end

  // FIFO storage carries no reset; pointers and counts define what is valid.
  // A flush leaves stored words in place, so writes are suppressed then too.
  always_ff @(posedge clk) begin
    if (rst && !flush && tx_push) begin
      tx_mem[tx_wptr_reg] <= data_bus_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && rx_push) begin
      rx_mem[rx_wptr_reg] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Register read-back
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] control_word;

  assign status_word = {11'b0, 5'(rx_count_reg), 3'b0, 5'(tx_count_reg), 2'b0,
                        rx_underflow_reg, tx_overflow_reg,
                        rx_empty, rx_full, tx_empty, tx_full};

  // Self-clearing command bits always read back as zero.
  assign control_word = {28'b0, irq_en_reg, 1'b0, tx_enable_reg, 1'b0};

  always_comb begin
    data_bus_read = 32'h0;
    if (bus_rd) begin
      case (reg_sel)
        REG_RXDATA:  data_bus_read = rx_empty ? 32'h0 : rx_head;
        REG_STATUS:  data_bus_read = status_word;
        REG_CONTROL: data_bus_read = control_word;
        default:     data_bus_read = 32'h0;
      endcase
    end
  end

  // Interrupt depends only on registered state.
  assign irq = irq_en_reg && !rx_empty;

endmodule

// File: tb/tb_io_mailbox.sv
module tb_io_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        wr_rd;
  logic [31:0] addr;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  io_mailbox #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cs             (cs),
    .wr_rd          (wr_rd),
    .addr           (addr),
    .data_bus_write (data_bus_write),
    .data_bus_read  (data_bus_read),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] R_TX   = 2'd0;
  localparam logic [1:0] R_RX   = 2'd1;
  localparam logic [1:0] R_STAT = 2'd2;
  localparam logic [1:0] R_CTRL = 2'd3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard queues: expected bus read data and expected TX stream words.
  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic [31:0] tx_exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s = %h", name, act);
    end else begin
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    string       n;
    if (rst === 1'b1) begin
      if (cs === 1'b1 && wr_rd === 1'b0) begin
        if (rd_exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_read: got %h, required no read", data_bus_read);
        end else begin
          e = rd_exp_q.pop_front();
          n = rd_name_q.pop_front();
          check(n, data_bus_read, e);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (tx_exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_tx: got %h, required no transfer", tx_data);
        end else begin
          e = tx_exp_q.pop_front();
          check("tx_word", tx_data, e);
        end
      end
    end
  end

  // All tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
    cs = 1'b1; wr_rd = 1'b1; addr = {28'h4000000, r, 2'b00}; data_bus_write = d;
    @(posedge clk); #1;
    cs = 1'b0; wr_rd = 1'b0; addr = 32'h0; data_bus_write = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] r, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    cs = 1'b1; wr_rd = 1'b0; addr = {28'h0000010, r, 2'b00};
    @(posedge clk); #1;
    cs = 1'b0; addr = 32'h0;
  endtask

  task automatic tx_write(input logic [31:0] d);
    tx_exp_q.push_back(d);
    bus_write(R_TX, d);
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b0; cs = 1'b0; wr_rd = 1'b0; addr = 32'h0; data_bus_write = 32'h0;
    tx_ready = 1'b0; rx_data = 32'h0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("idle_read_data", data_bus_read, 32'h0);
    bus_read(R_STAT, 32'h0000_000A, "reset_status");
    bus_read(R_CTRL, 32'h0, "reset_control");
    bus_read(R_TX, 32'h0, "txdata_read_zero");
    cs = 1'b1; wr_rd = 1'b1; addr = 32'h8; data_bus_write = 32'h0;
    #1 check("write_cycle_read_data", data_bus_read, 32'h0);
    @(posedge clk); #1 cs = 1'b0; wr_rd = 1'b0; addr = 32'h0;

    // TX fill past full, then drain in order
    bus_write(R_CTRL, 32'h2);
    for (int i = 1; i <= 8; i++) tx_write(i);
    bus_write(R_TX, 32'd9);
    bus_read(R_STAT, 32'h0000_0819, "tx_full_status");
    check("tx_valid_held", {31'b0, tx_valid}, 32'h1);
    check("tx_head", tx_data, 32'h1);
    repeat (2) @(posedge clk);
    #1 check("tx_head_stable", tx_data, 32'h1);
    tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("tx_drained_valid", {31'b0, tx_valid}, 32'h0);
    check("tx_queue_drained", tx_exp_q.size(), 32'h0);
    tx_ready = 1'b0;
    bus_write(R_CTRL, 32'h6);
    bus_read(R_STAT, 32'h0000_000A, "tx_sticky_cleared");
    bus_read(R_CTRL, 32'h2, "control_tx_enable");

    // RX fill to full, drain, underflow
    for (int i = 0; i < 8; i++) rx_push(32'hA0 + i);
    rx_data = 32'hA8; rx_valid = 1'b1;
    check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
    @(posedge clk); #1;
    bus_read(R_STAT, 32'h0008_0006, "rx_full_status");
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) bus_read(R_RX, 32'hA0 + i, "rx_word");
    bus_read(R_RX, 32'h0, "rx_empty_read");
    bus_read(R_STAT, 32'h0000_002A, "rx_underflow_status");
    bus_write(R_CTRL, 32'h6);
    bus_read(R_STAT, 32'h0000_000A, "rx_sticky_cleared");

    // Simultaneous RX push and CPU pop at count 3
    for (int i = 0; i < 3; i++) rx_push(32'hB0 + i);
    rx_data = 32'hB3; rx_valid = 1'b1;
    bus_read(R_RX, 32'hB0, "rx_simul_pop");
    rx_valid = 1'b0;
    bus_read(R_STAT, 32'h0003_0002, "rx_count_kept");
    for (int i = 1; i <= 3; i++) bus_read(R_RX, 32'hB0 + i, "rx_simul_order");

    // Interrupt and flush
    bus_write(R_CTRL, 32'hA);
    rx_data = 32'hC0; rx_valid = 1'b1;
    #1 check("irq_not_combinational", {31'b0, irq}, 32'h0);
    @(posedge clk); #1 rx_valid = 1'b0;
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_read(R_RX, 32'hC0, "irq_word");
    check("irq_cleared", {31'b0, irq}, 32'h0);
    bus_write(R_TX, 32'h11);
    bus_write(R_TX, 32'h22);
    rx_push(32'hD0);
    rx_push(32'hD1);
    bus_read(R_STAT, 32'h0002_0200, "pre_flush_status");
    check("pre_flush_irq", {31'b0, irq}, 32'h1);
    bus_write(R_CTRL, 32'hB);
    bus_read(R_STAT, 32'h0000_000A, "post_flush_status");
    bus_read(R_CTRL, 32'h0000_000A, "post_flush_control");
    check("post_flush_irq", {31'b0, irq}, 32'h0);
    check("post_flush_tx_valid", {31'b0, tx_valid}, 32'h0);

    // TX wrap: 20 cycles of simultaneous push and pop at count 5
    bus_write(R_CTRL, 32'h2);
    for (int i = 0; i < 5; i++) tx_write(32'h100 + i);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) tx_write(32'h105 + i);
    tx_ready = 1'b0;
    check("tx_wrap_pending", tx_exp_q.size(), 32'h5);
    bus_read(R_STAT, 32'h0000_0508, "tx_wrap_status");
    tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 tx_ready = 1'b0;
    check("tx_wrap_drained", tx_exp_q.size(), 32'h0);

    // RX wrap: 20 cycles of simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) rx_push(32'hE0 + i);
    for (int i = 0; i < 20; i++) begin
      rx_data = 32'hE5 + i; rx_valid = 1'b1;
      bus_read(R_RX, 32'hE0 + i, "rx_wrap_word");
    end
    rx_valid = 1'b0;
    bus_read(R_STAT, 32'h0005_0002, "rx_wrap_status");
    for (int i = 0; i < 5; i++) bus_read(R_RX, 32'hF4 + i, "rx_wrap_tail");
    bus_read(R_STAT, 32'h0000_000A, "rx_wrap_empty");

    // Reset mid-transfer
    bus_write(R_CTRL, 32'hA);
    bus_write(R_TX, 32'h55);
    rx_push(32'h66);
    rx_push(32'h77);
    rx_data = 32'h88; rx_valid = 1'b1; rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; rx_valid = 1'b0;
    bus_read(R_STAT, 32'h0000_000A, "midreset_status");
    bus_read(R_CTRL, 32'h0, "midreset_control");
    check("midreset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);

    @(posedge clk); #1;
    check("read_queue_drained", rd_exp_q.size(), 32'h0);
    check("tx_queue_empty", tx_exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
